// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: state, instruction-class and select-code definitions for the multi-cycle MIPS control FSM
package multicycle_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_JR       = 4'd12
  } state_e;
  typedef enum logic [3:0] {
    C_R, C_JR, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_IMM, C_ILL
  } cls_e;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [1:0] SRCB_4     = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;
  localparam logic [1:0] ALU_SUB    = 2'd1;
  localparam logic [1:0] ALU_FUNCT  = 2'd2;
  localparam logic [1:0] ALU_OPC    = 2'd3;
  localparam logic [1:0] PC_ALUOUT  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;
  localparam logic [1:0] PC_RS      = 2'd3;
  localparam logic [1:0] DST_RT     = 2'd0;
  localparam logic [1:0] DST_RD     = 2'd1;
  localparam logic [1:0] DST_RA     = 2'd2;
  localparam logic [1:0] M2R_ALU    = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctl_t;
endpackage

// File: rtl/multicycle_ctrl_opcode_classify.sv
// opcode_classify: maps opcode/funct to an instruction class and flags unsupported opcodes
module opcode_classify
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic       illegal_o
);
  always_comb begin
    cls_o = C_ILL;
    case (opcode_i)
      OP_RTYPE:                         cls_o = (funct_i == FN_JR) ? C_JR : C_R;
      OP_LW:                            cls_o = C_LW;
      OP_SW:                            cls_o = C_SW;
      OP_BEQ:                           cls_o = C_BEQ;
      OP_BNE:                           cls_o = C_BNE;
      OP_J:                             cls_o = C_J;
      OP_JAL:                           cls_o = C_JAL;
      OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: cls_o = C_IMM;
      default:                          cls_o = C_ILL;
    endcase
  end
  assign illegal_o = cls_o == C_ILL;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main FETCH/DECODE/EXEC/MEM/WB control FSM for the multi-cycle MIPS datapath
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] pc_src_o,
  output logic       ext_sign_o,
  output logic       illegal_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);
  state_e     state_q, state_d;
  cls_e       cls, cls_q;
  logic       illegal, illegal_q, bus_err_q, mem_st, timeout;
  logic [7:0] timer_q;
  logic [5:0] op_q;
  ctl_t       ctl;
  opcode_classify u_classify (
    .opcode_i  (opcode_i),
    .funct_i   (funct_i),
    .cls_o     (cls),
    .illegal_o (illegal)
  );
  assign mem_st  = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  assign timeout = mem_st && !mem_ready_i && timer_q == 8'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = cls == C_R                     ? S_R_EXEC   :
                            cls == C_JR                    ? S_JR       :
                            (cls == C_LW || cls == C_SW)   ? S_MEM_ADDR :
                            (cls == C_BEQ || cls == C_BNE) ? S_BRANCH   :
                            (cls == C_J || cls == C_JAL)   ? S_JUMP     :
                            cls == C_IMM                   ? S_I_EXEC   : S_FETCH;
      S_MEM_ADDR: state_d = cls_q == C_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : timeout ? S_FETCH : S_MEM_RD;
      S_MEM_WR:   state_d = (mem_ready_i || timeout) ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end
  // Timer only runs while a memory state keeps waiting; an abort restarts it even if FETCH is re-entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      timer_q   <= '0;
      op_q      <= '0;
      cls_q     <= C_ILL;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= (!mem_st || timeout || state_d != state_q) ? '0 : timer_q + 8'd1;
      op_q      <= state_q == S_DECODE ? opcode_i : op_q;
      cls_q     <= state_q == S_DECODE ? cls : cls_q;
      illegal_q <= state_q == S_DECODE && illegal;
      bus_err_q <= timeout;
    end
  end
  always_comb begin
    ctl = '0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = SRCB_4;
        ctl.pc_write  = mem_ready_i;
      end
      S_DECODE:   ctl.alu_src_b = SRCB_IMMSH;
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = M2R_MDR;
      end
      S_R_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = DST_RD;
      end
      S_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = PC_ALUOUT;
        ctl.pc_write  = (cls_q == C_BNE) ^ zero_i;
      end
      S_JUMP: begin
        ctl.pc_src     = PC_JUMP;
        ctl.pc_write   = 1'b1;
        ctl.reg_write  = cls_q == C_JAL;
        ctl.reg_dst    = cls_q == C_JAL ? DST_RA : DST_RT;
        ctl.mem_to_reg = cls_q == C_JAL ? M2R_PC : M2R_ALU;
      end
      S_JR: begin
        ctl.pc_src   = PC_RS;
        ctl.pc_write = 1'b1;
      end
      S_I_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALU_OPC;
      end
      S_I_WB:     ctl.reg_write = 1'b1;
      default:    ctl = '0;
    endcase
  end
  assign {pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o, reg_dst_o,
          mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o} = rst_i ? '0 : ctl;
  assign ext_sign_o = !rst_i && op_q != OP_ORI;
  assign illegal_o  = illegal_q;
  assign bus_err_o  = bus_err_q;
  assign state_o    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven plus hand-sequenced checks of the multi-cycle control FSM
module tb_multicycle_ctrl;
  logic       clk_i = 1'b0, rst_i = 1'b1, zero_i = 1'b0, mem_ready_i = 1'b0;
  logic [5:0] opcode_i = '0, funct_i = '0;
  logic       pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o;
  logic       alu_src_a_o, ext_sign_o, illegal_o, bus_err_o;
  logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, alu_op_o, pc_src_o;
  logic [3:0] state_o;
  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .pc_src_o(pc_src_o), .ext_sign_o(ext_sign_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o), .state_o(state_o)
  );
  always #5 clk_i = ~clk_i;
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, rw, mw, mr;
  } exp_t;
  typedef struct {
    string       name;
    logic [5:0]  op, fn;
    logic        z;
    int          n;
    logic [19:0] st;
    logic [4:0]  pcw, rw, mw, mr;
  } vec_t;
  exp_t  sb[$];
  vec_t  vecs[12];
  int    checks = 0, failures = 0, pcw_cnt = 0;
  string tag = "";
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic push(input logic [3:0] st, input logic pcw, input logic rw, input logic mw, input logic mr);
    sb.push_back(exp_t'{st, pcw, rw, mw, mr});
  endtask
  task automatic sample(input logic rdy);
    exp_t e;
    mem_ready_i = rdy;
    @(negedge clk_i);
    if (pc_write_o) pcw_cnt++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " state/pcw/rw/mw/mr"},
          {24'd0, state_o, pc_write_o, reg_write_o, mem_write_o, mem_read_o}, {24'd0, e});
    end
  endtask
  task automatic adv;
    @(posedge clk_i);
    #1;
  endtask
  task automatic tick(input logic rdy);
    sample(rdy);
    adv();
  endtask
  function automatic logic [31:0] all_outs();
    return {6'd0, state_o, pc_write_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_write_o,
            reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
            ext_sign_o, illegal_o, bus_err_o};
  endfunction
  initial begin
    //            name    op     fn     z     n  states     pcw       rw        mw        mr
    vecs[0]  = '{"add",  6'h00, 6'h20, 1'b0, 4, 20'h01670, 5'b10000, 5'b00010, 5'b00000, 5'b10000};
    vecs[1]  = '{"lw",   6'h23, 6'h00, 1'b0, 5, 20'h01234, 5'b10000, 5'b00001, 5'b00000, 5'b10010};
    vecs[2]  = '{"sw",   6'h2B, 6'h00, 1'b0, 4, 20'h01250, 5'b10000, 5'b00000, 5'b00010, 5'b10000};
    vecs[3]  = '{"beq1", 6'h04, 6'h00, 1'b1, 3, 20'h01800, 5'b10100, 5'b00000, 5'b00000, 5'b10000};
    vecs[4]  = '{"beq0", 6'h04, 6'h00, 1'b0, 3, 20'h01800, 5'b10000, 5'b00000, 5'b00000, 5'b10000};
    vecs[5]  = '{"bne0", 6'h05, 6'h00, 1'b0, 3, 20'h01800, 5'b10100, 5'b00000, 5'b00000, 5'b10000};
    vecs[6]  = '{"bne1", 6'h05, 6'h00, 1'b1, 3, 20'h01800, 5'b10000, 5'b00000, 5'b00000, 5'b10000};
    vecs[7]  = '{"j",    6'h02, 6'h00, 1'b0, 3, 20'h01900, 5'b10100, 5'b00000, 5'b00000, 5'b10000};
    vecs[8]  = '{"jal",  6'h03, 6'h00, 1'b0, 3, 20'h01900, 5'b10100, 5'b00100, 5'b00000, 5'b10000};
    vecs[9]  = '{"jr",   6'h00, 6'h08, 1'b0, 3, 20'h01c00, 5'b10100, 5'b00000, 5'b00000, 5'b10000};
    vecs[10] = '{"addi", 6'h08, 6'h00, 1'b0, 4, 20'h01ab0, 5'b10000, 5'b00010, 5'b00000, 5'b10000};
    vecs[11] = '{"ori",  6'h0D, 6'h00, 1'b0, 4, 20'h01ab0, 5'b10000, 5'b00010, 5'b00000, 5'b10000};
    // Reset held with ready high: FETCH's pc_write must still be masked.
    mem_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset outputs", all_outs(), 32'd0);
    adv();
    rst_i = 1'b0;
    foreach (vecs[k]) begin
      tag = vecs[k].name;
      opcode_i = vecs[k].op;
      funct_i  = vecs[k].fn;
      zero_i   = vecs[k].z;
      for (int i = 0; i < vecs[k].n; i++)
        push(vecs[k].st[19-4*i -: 4], vecs[k].pcw[4-i], vecs[k].rw[4-i], vecs[k].mw[4-i], vecs[k].mr[4-i]);
      for (int i = 0; i < vecs[k].n; i++) tick(1'b1);
    end
    tag = "lw_wait"; opcode_i = 6'h23; funct_i = 6'h00; pcw_cnt = 0;
    push(0, 0, 0, 0, 1); push(0, 0, 0, 0, 1); push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0); push(3, 0, 0, 0, 1); push(3, 0, 0, 0, 1); push(3, 0, 0, 0, 1);
    push(4, 0, 1, 0, 0);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b1); tick(1'b1);
    sample(1'b0);
    chk("lw_wait iord", {31'd0, iord_o}, 32'd1);
    adv();
    tick(1'b0); tick(1'b1);
    sample(1'b1);
    chk("lw_wait mem_to_reg", {30'd0, mem_to_reg_o}, 32'd1);
    chk("lw_wait reg_dst", {30'd0, reg_dst_o}, 32'd0);
    adv();
    chk("lw_wait pc_write count", pcw_cnt, 32'd1);
    for (int p = 0; p < 2; p++) begin
      tag = p == 0 ? "ori_ext" : "addi_ext";
      opcode_i = p == 0 ? 6'h0D : 6'h08;
      push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(10, 0, 0, 0, 0); push(11, 0, 1, 0, 0);
      tick(1'b1); tick(1'b1);
      sample(1'b1);
      chk({tag, " ext_sign"}, {31'd0, ext_sign_o}, p == 0 ? 32'd0 : 32'd1);
      chk({tag, " alu_src_b"}, {30'd0, alu_src_b_o}, 32'd2);
      chk({tag, " alu_op"}, {30'd0, alu_op_o}, 32'd3);
      adv();
      tick(1'b1);
    end
    tag = "illegal"; opcode_i = 6'h3F;
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(0, 0, 0, 0, 1); push(0, 0, 0, 0, 1);
    tick(1'b1);
    sample(1'b1);
    chk("illegal before", {31'd0, illegal_o}, 32'd0);
    adv();
    sample(1'b0);
    chk("illegal pulse", {31'd0, illegal_o}, 32'd1);
    adv();
    sample(1'b0);
    chk("illegal after", {31'd0, illegal_o}, 32'd0);
    adv();
    tag = "sw_timeout"; opcode_i = 6'h2B;
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(2, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) push(5, 0, 0, 1, 0);
    push(0, 0, 0, 0, 1); push(0, 0, 0, 0, 1);
    tick(1'b1); tick(1'b1); tick(1'b1);
    for (int i = 0; i < 16; i++) begin
      sample(1'b0);
      if (i == 15) chk("bus_err before timeout", {31'd0, bus_err_o}, 32'd0);
      adv();
    end
    sample(1'b0);
    chk("bus_err pulse", {31'd0, bus_err_o}, 32'd1);
    adv();
    sample(1'b0);
    chk("bus_err after", {31'd0, bus_err_o}, 32'd0);
    adv();
    tag = "jal_sel"; opcode_i = 6'h03;
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(9, 1, 1, 0, 0);
    tick(1'b1); tick(1'b1);
    sample(1'b1);
    chk("jal reg_dst", {30'd0, reg_dst_o}, 32'd2);
    chk("jal mem_to_reg", {30'd0, mem_to_reg_o}, 32'd2);
    chk("jal pc_src", {30'd0, pc_src_o}, 32'd2);
    adv();
    tag = "beq_sel"; opcode_i = 6'h04; zero_i = 1'b1;
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(8, 1, 0, 0, 0);
    tick(1'b1); tick(1'b1);
    sample(1'b1);
    chk("beq pc_src", {30'd0, pc_src_o}, 32'd1);
    chk("beq alu_op", {30'd0, alu_op_o}, 32'd1);
    adv();
    tag = "rst_mid"; opcode_i = 6'h00; funct_i = 6'h20; zero_i = 1'b0;
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(6, 0, 0, 0, 0);
    tick(1'b1); tick(1'b1);
    sample(1'b1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid outputs", all_outs(), 32'd0);
    #1;
    rst_i = 1'b0;
    mem_ready_i = 1'b0;
    adv();
    push(0, 0, 0, 0, 1);
    tick(1'b0);
    push(0, 1, 0, 0, 1); push(1, 0, 0, 0, 0); push(6, 0, 0, 0, 0); push(7, 0, 1, 0, 0);
    repeat (4) tick(1'b1);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
